context_fetch_ctrl: RTL and testbench

//   Sequences byte reads from the syscall context memory over its readM/ready four-phase handshake.

---
 rtl/context_fetch_ctrl_if.sv | 27 ++
 rtl/context_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_context_fetch_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/context_fetch_ctrl_if.sv
// Bundles the context-memory handshake, start/status and output stream of context_fetch_ctrl.
// The master side is the controller. The slave side is the memory, datapath and sequencer.
interface context_fetch_ctrl_if #(
    parameter int WORD_BYTES = 4
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic                    readM;
    logic                    mem_ready;
    logic [7:0]              mem_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [8*WORD_BYTES-1:0] out_data;
    logic                    out_last;

    modport master (
        input  start, mem_ready, mem_data, out_ready,
        output busy, done, err, readM, out_valid, out_data, out_last
    );

    modport slave (
        output start, mem_ready, mem_data, out_ready,
        input  busy, done, err, readM, out_valid, out_data, out_last
    );
endinterface

// File: rtl/context_fetch_ctrl.sv
// Fetches one context of NUM_BYTES bytes over the readM/mem_ready four-phase handshake.
// Packs the bytes into WORD_BYTES-wide words and emits them on a valid/ready stream.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | readM low, waiting for a stale mem_ready to drop
// REQ    | readM high, waiting for mem_ready, then capture byte
// REL    | readM low, waiting for mem_ready to drop
// OUT    | word held on out_data until out_ready
// FIN    | one-cycle done pulse
// ERR    | handshake timed out; waiting for mem_ready low
module context_fetch_ctrl #(
    parameter int NUM_BYTES  = 16,
    parameter int WORD_BYTES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    context_fetch_ctrl_if.master bus
);
    localparam int CW = $clog2(NUM_BYTES + 1);
    localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, REQ, REL, OUT, FIN, ERR} state_t;

    state_t                  state, state_nxt;
    logic                    sync1, rdy_s;
    logic [CW-1:0]           count;
    logic [LW-1:0]           lane;
    logic [TW-1:0]           tmo;
    logic [8*WORD_BYTES-1:0] data;
    logic                    err_q;
    logic                    tmo_hit, count_full, word_full;

    assign tmo_hit    = (tmo == TW'(TIMEOUT - 1));
    assign count_full = (count == CW'(NUM_BYTES));
    // REL is only reached right after a capture, so a wrapped lane means the word is full
    assign word_full  = (lane == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sync1 <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            state <= state_nxt;
            sync1 <= bus.mem_ready;
            rdy_s <= sync1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SETTLE;
            SETTLE:  if (!rdy_s) state_nxt = REQ;
                     else if (tmo_hit) state_nxt = ERR;
            REQ:     if (rdy_s) state_nxt = REL;
                     else if (tmo_hit) state_nxt = ERR;
            REL:     if (!rdy_s) state_nxt = (word_full || count_full) ? OUT : REQ;
                     else if (tmo_hit) state_nxt = ERR;
            OUT:     if (bus.out_ready) state_nxt = count_full ? FIN : REQ;
            FIN:     state_nxt = IDLE;
            ERR:     if (!rdy_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = (state == FIN);
        bus.readM     = (state == REQ);
        bus.out_valid = (state == OUT);
        bus.out_data  = (state == OUT) ? data : '0;
        bus.out_last  = (state == OUT) && count_full;
        bus.err       = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            lane  <= '0;
            tmo   <= '0;
            data  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                tmo <= '0;
            end else if (state == SETTLE || state == REQ || state == REL) begin
                tmo <= tmo + TW'(1);
            end

            if (state == IDLE && bus.start) begin
                count <= '0;
                lane  <= '0;
                data  <= '0;
                err_q <= 1'b0;
            end

            if (state == REQ && rdy_s) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (lane == LW'(i)) data[8*i +: 8] <= bus.mem_data;
                end
                count <= count + CW'(1);
                lane  <= (lane == LW'(WORD_BYTES - 1)) ? '0 : lane + LW'(1);
            end

            if (state == OUT && bus.out_ready && !count_full) data <= '0;

            if (state_nxt == ERR && state != ERR) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_context_fetch_ctrl.sv
// Scoreboard bench for context_fetch_ctrl: a default 16/4 instance and a 6/4 instance,
// each driven by a behavioural four-phase context memory.
module tb_context_fetch_ctrl;
    localparam int TMO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    context_fetch_ctrl_if #(.WORD_BYTES(4)) a ();
    context_fetch_ctrl_if #(.WORD_BYTES(4)) b ();

    context_fetch_ctrl #(.NUM_BYTES(16), .WORD_BYTES(4), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .rst(rst), .bus(a.master));
    context_fetch_ctrl #(.NUM_BYTES(6), .WORD_BYTES(4), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .rst(rst), .bus(b.master));

    int errors = 0;
    int checks = 0;

    logic [32:0] exp_q_a[$];
    logic [32:0] exp_q_b[$];
    logic [32:0] e_a, e_b;
    int  wcnt_a = 0, wcnt_b = 0;
    int  rm_pulses = 0, rm_hi = 0, done_cnt_a = 0, done_cnt_b = 0;
    logic rm_prev = 1'b0;
    int  stall_idx = -1, stall_left = 0;
    bit  stall_first = 1'b0;
    logic [31:0] held = '0;
    int  mem_dly = 0, dly_cnt = 0, addr = 0;
    bit  mem_tie0 = 1'b0, mem_hold = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        a.start = 1'b1;
        tick(1);
        a.start = 1'b0;
    endtask

    task automatic push_ctx_a();
        for (int w = 0; w < 4; w++)
            exp_q_a.push_back({w == 3, 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    endtask

    task automatic clear_stats();
        rm_pulses  = 0;
        rm_hi      = 0;
        done_cnt_a = 0;
        wcnt_a     = 0;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (done_cnt_a == 0 && n < 2000) begin
            tick(1);
            n++;
        end
        check_val({tag, "_done_seen"}, 64'(done_cnt_a > 0), 1);
        tick(3);
        check_val({tag, "_busy"}, a.busy, 0);
        check_val({tag, "_done_cycles"}, done_cnt_a, 1);
        check_val({tag, "_readM_pulses"}, rm_pulses, 16);
        check_val({tag, "_words"}, wcnt_a, 4);
        check_val({tag, "_queue_left"}, exp_q_a.size(), 0);
    endtask

    // four-phase context memory for instance A; byte value = address
    always @(negedge clk) begin
        if (mem_tie0) a.mem_ready = 1'b0;
        else if (mem_hold) a.mem_ready = 1'b1;
        else if (a.readM !== a.mem_ready) begin
            if (dly_cnt >= mem_dly) begin
                if (a.readM) begin
                    a.mem_data = 8'(addr);
                    addr++;
                end
                a.mem_ready = a.readM;
                dly_cnt = 0;
            end else dly_cnt++;
        end else dly_cnt = 0;
    end

    always @(negedge clk) begin
        b.mem_ready = b.readM;
        b.mem_data  = 8'h80;
    end

    always @(negedge clk) begin
        if (a.readM && !rm_prev) rm_pulses++;
        if (a.readM) rm_hi++;
        rm_prev = a.readM;
        if (a.done) done_cnt_a++;
        if (a.out_valid && wcnt_a == stall_idx && stall_left > 0) begin
            a.out_ready = 1'b0;
            if (stall_first) begin
                held = a.out_data;
                stall_first = 1'b0;
            end else check_val("stall_data", a.out_data, held);
            check_val("stall_readM", a.readM, 0);
            stall_left--;
        end else begin
            a.out_ready = 1'b1;
            if (a.out_valid) begin
                if (exp_q_a.size() == 0) check_val("a_extra_word", exp_q_a.size(), 1);
                else begin
                    e_a = exp_q_a.pop_front();
                    check_val("a_word", a.out_data, e_a[31:0]);
                    check_val("a_last", a.out_last, e_a[32]);
                end
                wcnt_a++;
            end
        end
    end

    always @(negedge clk) begin
        if (b.done) done_cnt_b++;
        if (b.out_valid) begin
            if (exp_q_b.size() == 0) check_val("b_extra_word", exp_q_b.size(), 1);
            else begin
                e_b = exp_q_b.pop_front();
                check_val("b_word", b.out_data, e_b[31:0]);
                check_val("b_last", b.out_last, e_b[32]);
            end
            wcnt_b++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n;
        a.start = 1'b0; a.mem_ready = 1'b0; a.mem_data = '0; a.out_ready = 1'b1;
        b.start = 1'b0; b.mem_ready = 1'b0; b.mem_data = '0; b.out_ready = 1'b1;
        tick(3);
        check_val("rst_busy", a.busy, 0);
        check_val("rst_readM", a.readM, 0);
        check_val("rst_done", a.done, 0);
        check_val("rst_err", a.err, 0);
        check_val("rst_valid", a.out_valid, 0);
        check_val("rst_data", a.out_data, 0);
        check_val("rst_last", a.out_last, 0);
        check_val("rst_b_busy", b.busy, 0);
        rst = 1'b0;
        tick(2);

        // 1: straight fetch, no backpressure
        addr = 0; mem_dly = 0; clear_stats(); push_ctx_a();
        pulse_start_a();
        wait_idle_a("t1");

        // 2: second word stalled for 20 cycles, slower memory
        addr = 0; mem_dly = 2; clear_stats(); push_ctx_a();
        stall_idx = 1; stall_left = 20; stall_first = 1'b1;
        pulse_start_a();
        wait_idle_a("t2");
        check_val("t2_stall_done", stall_left, 0);
        stall_idx = -1;

        // 3: short final word on the 6-byte instance
        done_cnt_b = 0; wcnt_b = 0;
        exp_q_b.push_back({1'b0, 32'h8080_8080});
        exp_q_b.push_back({1'b1, 32'h0000_8080});
        b.start = 1'b1; tick(1); b.start = 1'b0;
        n = 0;
        while (done_cnt_b == 0 && n < 1000) begin tick(1); n++; end
        tick(2);
        check_val("t3_done_cycles", done_cnt_b, 1);
        check_val("t3_words", wcnt_b, 2);
        check_val("t3_queue_left", exp_q_b.size(), 0);
        check_val("t3_busy", b.busy, 0);

        // 4: memory never answers
        mem_tie0 = 1'b1; mem_dly = 0; clear_stats();
        pulse_start_a();
        n = 0;
        while (!a.err && n < 1000) begin tick(1); n++; end
        check_val("t4_err", a.err, 1);
        tick(2);
        check_val("t4_readM", a.readM, 0);
        check_val("t4_busy", a.busy, 0);
        check_val("t4_readM_cycles", rm_hi, TMO);
        check_val("t4_no_done", done_cnt_a, 0);
        check_val("t4_no_words", wcnt_a, 0);
        check_val("t4_err_sticky", a.err, 1);
        mem_tie0 = 1'b0; addr = 0; mem_dly = 1; clear_stats(); push_ctx_a();
        pulse_start_a();
        check_val("t4_err_clear", a.err, 0);
        wait_idle_a("t4b");

        // 5: reset while REQ sees mem_ready high
        addr = 0; mem_dly = 0; clear_stats();
        pulse_start_a();
        n = 0;
        while (!(a.readM && a.mem_ready) && n < 100) begin tick(1); n++; end
        check_val("t5_in_req", 64'(a.readM && a.mem_ready), 1);
        rst = 1'b1; mem_hold = 1'b1;
        tick(1);
        check_val("t5_rst_readM", a.readM, 0);
        check_val("t5_rst_busy", a.busy, 0);
        check_val("t5_rst_valid", a.out_valid, 0);
        check_val("t5_rst_data", a.out_data, 0);
        check_val("t5_rst_done", a.done, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        addr = 0; clear_stats(); push_ctx_a();
        pulse_start_a();
        for (int i = 0; i < 6; i++) begin
            check_val("t5_settle_busy", a.busy, 1);
            check_val("t5_settle_readM", a.readM, 0);
            tick(1);
        end
        mem_hold = 1'b0;
        wait_idle_a("t5");

        // 6: start while busy and in the done cycle
        addr = 0; mem_dly = 0; clear_stats(); push_ctx_a();
        pulse_start_a();
        tick(30);
        check_val("t6_busy_mid", a.busy, 1);
        pulse_start_a();
        n = 0;
        while (!a.done && n < 2000) begin tick(1); n++; end
        check_val("t6_done_seen", a.done, 1);
        a.start = 1'b1;
        tick(1);
        a.start = 1'b0;
        tick(60);
        check_val("t6_busy", a.busy, 0);
        check_val("t6_done_cycles", done_cnt_a, 1);
        check_val("t6_readM_pulses", rm_pulses, 16);
        check_val("t6_words", wcnt_a, 4);
        check_val("t6_queue_left", exp_q_a.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
